// File: rtl/oct_req_arbiter_if.sv
// Request/offer bundle for oct_req_arbiter: request lines in, one-hot grant offer out.
// slave = arbiter side, master = requester/consumer side.
interface oct_req_arbiter_if #(
   parameter int DROP_CNT_W = 8
);
   logic [7:0]            req_i;
   logic                  ready_i;
   logic                  drop_clr_i;
   logic                  valid_o;
   logic [7:0]            grant_o;
   logic [2:0]            code_o;
   logic [7:0]            pend_o;
   logic [DROP_CNT_W-1:0] drop_cnt_o;
   logic                  dbg_state_o;

   // Handshake: an offer (valid_o, grant_o, code_o) is held stable while valid_o=1 and
   // ready_i=0; it is consumed on a clock edge where valid_o=1 and ready_i=1.
   // ready_i is ignored while valid_o=0.
   modport slave (
      input  req_i, ready_i, drop_clr_i,
      output valid_o, grant_o, code_o, pend_o, drop_cnt_o, dbg_state_o
   );

   modport master (
      output req_i, ready_i, drop_clr_i,
      input  valid_o, grant_o, code_o, pend_o, drop_cnt_o, dbg_state_o
   );
endinterface

// File: rtl/oct_req_arbiter.sv
// Eight-line rising-edge request capture with one-at-a-time one-hot offer and lost-request counter.
// Define OCT_ARB_RR_EN for round-robin selection; otherwise lowest pending index wins.
module oct_req_arbiter #(
   parameter int DROP_CNT_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   oct_req_arbiter_if.slave bus
);
   typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_e;

   localparam logic [DROP_CNT_W+3:0] CNT_MAX = {4'b0, {DROP_CNT_W{1'b1}}};

   state_e                state_q, state_d;
   logic [7:0]            req_q, pend_q, pend_d;
   logic [7:0]            grant_q, grant_d;
   logic [2:0]            code_q, code_d, sel_idx;
   logic                  valid_q, valid_d;
   logic [7:0]            edge_w, acc_vec, drop_vec;
   logic                  accept;
   logic [3:0]            drop_num;
   logic [DROP_CNT_W+3:0] drop_sum;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   assign edge_w   = bus.req_i & ~req_q;
   assign accept   = valid_q & bus.ready_i;
   assign acc_vec  = accept ? grant_q : 8'h00;
   // An edge on a bit being accepted re-arms it instead of counting as a drop.
   assign pend_d   = edge_w | (pend_q & ~acc_vec);
   assign drop_vec = edge_w & pend_q & ~acc_vec;

   always_comb begin
      drop_num = 4'd0;
      for (int k = 0; k < 8; k++) begin
         drop_num = drop_num + {3'b000, drop_vec[k]};
      end
      drop_sum = {4'b0, drop_cnt_q} + {{DROP_CNT_W{1'b0}}, drop_num};
      if (bus.drop_clr_i) begin
         drop_cnt_d = '0;
      end else if (drop_sum > CNT_MAX) begin
         drop_cnt_d = {DROP_CNT_W{1'b1}};
      end else begin
         drop_cnt_d = drop_sum[DROP_CNT_W-1:0];
      end
   end

`ifdef OCT_ARB_RR_EN
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] cand;

   // Walk downward so the candidate closest to the pointer is written last and wins.
   always_comb begin
      sel_idx = 3'd0;
      cand    = 3'd0;
      for (int off = 7; off >= 0; off--) begin
         cand = ptr_q + 3'(off);
         if (pend_q[cand]) sel_idx = cand;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 3'd0;
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      sel_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pend_q[i]) sel_idx = 3'(i);
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      grant_d = grant_q;
      code_d  = code_q;
`ifdef OCT_ARB_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               state_d = S_OFFER;
               valid_d = 1'b1;
               grant_d = 8'b1 << sel_idx;
               code_d  = sel_idx;
            end
         end
         S_OFFER: begin
            if (bus.ready_i) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               grant_d = 8'h00;
               code_d  = 3'd0;
`ifdef OCT_ARB_RR_EN
               ptr_d   = code_q + 3'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= 8'h00;
         pend_q     <= 8'h00;
         grant_q    <= 8'h00;
         code_q     <= 3'd0;
         valid_q    <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= bus.req_i;
         pend_q     <= pend_d;
         grant_q    <= grant_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.valid_o     = valid_q;
   assign bus.grant_o     = grant_q;
   assign bus.code_o      = code_q;
   assign bus.pend_o      = pend_q;
   assign bus.drop_cnt_o  = drop_cnt_q;
   assign bus.dbg_state_o = (state_q == S_OFFER);
endmodule
